// File: rtl/dmem_access_ctrl_if.sv
// Request/response handshake and data-memory bus for dmem_access_ctrl.
// slave: the controller's view; master: the core plus memory environment.
interface dmem_access_ctrl_if #(
  parameter int unsigned WordSize = 32
) ();
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [WordSize-1:0] req_addr;
  logic [WordSize-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [WordSize-1:0] resp_rdata;
  logic                resp_err;
  logic [WordSize-1:0] Mem_Addr;
  logic                Mem_rd;
  logic                Mem_wr;
  logic [WordSize-1:0] Mem_DIN;
  logic [WordSize-1:0] Mem_DOUT;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, Mem_DOUT,
    output req_ready, resp_valid, resp_rdata, resp_err, Mem_Addr, Mem_rd, Mem_wr, Mem_DIN
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, Mem_DOUT,
    input  req_ready, resp_valid, resp_rdata, resp_err, Mem_Addr, Mem_rd, Mem_wr, Mem_DIN
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: takes one load/store at a time, holds the memory
// strobes and address stable for a fixed number of cycles, then returns a response.
module dmem_access_ctrl #(
  parameter int unsigned WordSize = 32,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_WAIT  = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  dmem_access_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam int unsigned MaxWait = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  // Counter only needs to hold MaxWait-1.
  localparam int unsigned CntW    = (MaxWait > 1) ? $clog2(MaxWait) : 1;
  localparam logic [CntW-1:0] RdInit = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] WrInit = CntW'(WR_WAIT - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WordSize-1:0] mem_addr_q, mem_addr_d;
  logic [WordSize-1:0] mem_din_q, mem_din_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [WordSize-1:0] resp_rdata_q, resp_rdata_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately, memory is never touched.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = StResp;
          end else if (bus.req_we) begin
            mem_wr_d   = 1'b1;
            mem_addr_d = bus.req_addr;
            mem_din_d  = bus.req_wdata;
            cnt_d      = WrInit;
            state_d    = StWrite;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = bus.req_addr;
            cnt_d      = RdInit;
            state_d    = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          resp_rdata_d = bus.Mem_DOUT;
          mem_rd_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          state_d      = StResp;
        end
      end
      StWrite: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          resp_rdata_d = '0;
          mem_wr_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; async reset drops the memory strobes at once.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Mem_DIN    = mem_din_q;
  assign bus.Mem_rd     = mem_rd_q;
  assign bus.Mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a negedge-write / async-read memory model
// and a response scoreboard.
module tb_dmem_access_ctrl;
  localparam int unsigned W = 32;

  logic CLK = 1'b0;
  logic Reset;
  logic mem_clear;

  always #5 CLK = ~CLK;

  dmem_access_ctrl_if #(.WordSize(W)) bus ();

  dmem_access_ctrl #(.WordSize(W), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  // Memory model: 64 words, written on the falling edge, read combinationally.
  logic [W-1:0] mem [0:63];
  always @(negedge CLK or posedge mem_clear) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bus.Mem_wr) begin
      mem[bus.Mem_Addr[7:2]] <= bus.Mem_DIN;
    end
  end
  assign bus.Mem_DOUT = mem[bus.Mem_Addr[7:2]];

  typedef struct packed {
    logic [W-1:0] rdata;
    logic         err;
  } resp_t;

  resp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge (caller is in IDLE, 1 ns after an edge).
  task automatic issue(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " req_ready"}, bus.req_ready, 1);
    check({tag, " resp_valid"}, bus.resp_valid, 0);
    check({tag, " resp_err"}, bus.resp_err, 0);
    check({tag, " resp_rdata"}, bus.resp_rdata, 0);
    check({tag, " Mem_rd"}, bus.Mem_rd, 0);
    check({tag, " Mem_wr"}, bus.Mem_wr, 0);
    check({tag, " Mem_Addr"}, bus.Mem_Addr, 0);
    check({tag, " Mem_DIN"}, bus.Mem_DIN, 0);
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, then handshake it.
  task automatic take_resp(input string tag);
    resp_t e;
    int waited = 0;
    while (bus.resp_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, " resp_valid"}, bus.resp_valid, 1);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " rdata"}, bus.resp_rdata, e.rdata);
      check({tag, " err"}, bus.resp_err, W'(e.err));
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, " post valid"}, bus.resp_valid, 0);
    check({tag, " post err"}, bus.resp_err, 0);
    check({tag, " post ready"}, bus.req_ready, 1);
    check({tag, " post rd"}, bus.Mem_rd, 0);
    check({tag, " post wr"}, bus.Mem_wr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset          = 1'b1;
    mem_clear      = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    #2 mem_clear = 1'b0;
    tick();
    tick();
    check_reset("rst_init");
    Reset = 1'b0;
    tick();
    check_reset("idle");

    // Store 0xDEADBEEF to 0x10: Mem_wr for exactly two cycles, response on 2nd edge.
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    sb.push_back('{rdata: '0, err: 1'b0});
    check("st c1 wr", bus.Mem_wr, 1);
    check("st c1 rd", bus.Mem_rd, 0);
    check("st c1 addr", bus.Mem_Addr, 32'h10);
    check("st c1 din", bus.Mem_DIN, 32'hDEADBEEF);
    check("st c1 ready", bus.req_ready, 0);
    check("st c1 valid", bus.resp_valid, 0);
    tick();
    check("st c2 wr", bus.Mem_wr, 1);
    check("st c2 valid", bus.resp_valid, 0);
    tick();
    check("st c3 wr", bus.Mem_wr, 0);
    check("st c3 valid", bus.resp_valid, 1);
    take_resp("st");
    check("st mem4", mem[4], 32'hDEADBEEF);

    // Load back from 0x10.
    issue(1'b0, 32'h10, 32'h0);
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    check("ld c1 rd", bus.Mem_rd, 1);
    check("ld c1 wr", bus.Mem_wr, 0);
    check("ld c1 addr", bus.Mem_Addr, 32'h10);
    check("ld c1 valid", bus.resp_valid, 0);
    tick();
    check("ld c2 rd", bus.Mem_rd, 1);
    check("ld c2 valid", bus.resp_valid, 0);
    tick();
    check("ld c3 rd", bus.Mem_rd, 0);
    check("ld c3 valid", bus.resp_valid, 1);
    take_resp("ld");

    // Backpressure: response held 5 cycles while a store waits on req_valid.
    issue(1'b0, 32'h10, 32'h0);
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    tick();
    tick();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h14;
    bus.req_wdata = 32'hCAFEF00D;
    sb.push_back('{rdata: '0, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      check("bp valid", bus.resp_valid, 1);
      check("bp rdata", bus.resp_rdata, 32'hDEADBEEF);
      check("bp ready", bus.req_ready, 0);
      check("bp wr", bus.Mem_wr, 0);
      tick();
    end
    take_resp("bp");
    tick();
    bus.req_valid = 1'b0;
    check("bp2 wr", bus.Mem_wr, 1);
    check("bp2 addr", bus.Mem_Addr, 32'h14);
    check("bp2 din", bus.Mem_DIN, 32'hCAFEF00D);
    take_resp("bp2");
    check("bp2 mem5", mem[5], 32'hCAFEF00D);

    // Misaligned store: error response one edge after accept, no memory strobe.
    issue(1'b1, 32'h13, 32'h11111111);
    sb.push_back('{rdata: '0, err: 1'b1});
    check("mis valid", bus.resp_valid, 1);
    check("mis err", bus.resp_err, 1);
    check("mis rdata", bus.resp_rdata, 0);
    check("mis wr", bus.Mem_wr, 0);
    check("mis rd", bus.Mem_rd, 0);
    tick();
    check("mis wr2", bus.Mem_wr, 0);
    take_resp("mis");
    check("mis mem4", mem[4], 32'hDEADBEEF);
    check("mis mem5", mem[5], 32'hCAFEF00D);

    // Reset mid-cycle during a read: outputs return to reset values at once.
    issue(1'b0, 32'h14, 32'h0);
    check("rr rd", bus.Mem_rd, 1);
    #2 Reset = 1'b1;
    #1 check_reset("rst_mid");
    #1 Reset = 1'b0;
    tick();
    tick();
    check("rr no resp", bus.resp_valid, 0);
    check("rr ready", bus.req_ready, 1);

    // Reset during write cycle 1 before the negedge: write must not happen.
    issue(1'b1, 32'h20, 32'h12345678);
    check("rw wr", bus.Mem_wr, 1);
    #1 Reset = 1'b1;
    #1 check("rw wr drop", bus.Mem_wr, 0);
    #5 Reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rw no resp", bus.resp_valid, 0);
      tick();
    end
    check("rw mem8", mem[8], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
